multi_debouncer: RTL
====================

Name: multi_debouncer

Overview:
- Parametrised, multi-channel successor to the single-button debouncer.
- Synchronises N raw button/switch inputs and filters each against a programmable stability window.
- Outputs a clean level per channel plus single-cycle press and release strobes.
- Sits between board pins and the control FSM / ALU operand-entry logic; all outputs are in the clock domain.

Parameters:
- CHANNELS, 4, number of independent inputs.
- CNT_W, 32, width of the delay input and of each per-channel counter.
- ACTIVE_LOW, 1, 1 = raw input low means pressed (button to ground); 0 = high means pressed.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  filter enable; low freezes the filter.
- delay  input  CNT_W  stability window in cycles, shared by all channels, sampled live.
- raw_in  input  CHANNELS  unsynchronised pin levels.
- pressed  output  CHANNELS  debounced level, 1 = pressed (polarity normalised).
- press_pulse  output  CHANNELS  1-cycle strobe on debounced 0->1.
- release_pulse  output  CHANNELS  1-cycle strobe on debounced 1->0.

Behaviour:
- Reset (async assert, sync-safe release):
  - Synchroniser flops load the inactive level (1 if ACTIVE_LOW, else 0).
  - Counters clear to 0.
  - pressed, press_pulse and release_pulse clear to 0.
- Synchroniser: 2 flops per channel, then polarity normalisation giving sample s[i] (1 = pressed).
- Per channel, each cycle with enable=1:
  - s != pressed and count >= delay: pressed <= s, count <= 0, the matching pulse is asserted for exactly this one cycle.
  - s != pressed and count < delay: count <= count+1, saturating at all-ones.
  - s == pressed: count <= 0, i.e. any glitch restarts the window.
- Latency: a clean edge on raw_in reaches pressed after 2 + delay + 1 cycles. The pulse is asserted in the same cycle pressed changes.
- delay=0: flips on the first differing sample, which is pass-through plus synchroniser.
- delay changed mid-count: the >= compare applies immediately. Lowering delay below the current count flips on the next differing cycle.
- Pulses are registered, deasserted in every other cycle, and never overlap press/release on one channel.
- enable=0:
  - Counters held at 0, pressed held, pulses 0.
  - The synchroniser keeps running.
  - Re-enable starts a fresh window.
- Reset asserted mid-count: everything returns to reset values at once. No pulse is generated by reset or by its release.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.

Optional Feature:
- Macro: MULTI_DEBOUNCER_REPEAT_EN.
- Defined, ports added:
  - repeat_delay  input  CNT_W
  - repeat_pulse  output  CHANNELS
- Defined, behaviour:
  - While pressed[i]=1 and the sample stays 1, a separate hold counter increments.
  - When the hold counter >= repeat_delay, repeat_pulse[i] fires for 1 cycle and the hold counter clears, giving auto-repeat every repeat_delay+1 cycles.
  - The hold counter clears on release, on enable=0 and on reset.
  - The first repeat comes repeat_delay+1 cycles after press_pulse.
- Undefined: the ports are absent, no hold counters are built, and behaviour is exactly as above.

Decomposition:
- Shared package debounce_pkg: inactive-level constant function by ACTIVE_LOW, the default CNT_W, and the saturating-increment function.
- Natural sub-module: debounce_channel holds one channel's synchroniser, counter, state, pulses and optional repeat logic. multi_debouncer instantiates CHANNELS copies via generate and fans out delay/enable.

Test Plan:
- Reset/idle: raw_in=4'b1111, ACTIVE_LOW=1, delay=10 -> pressed=0 and no pulses for 100 cycles; reset asserted mid-run clears all outputs asynchronously.
- Clean press: ch0 driven low at cycle t, delay=10 -> pressed[0]=1 and press_pulse[0]=1 for 1 cycle at t+13; holding 50 cycles gives no further pulses; release gives release_pulse[0] at release+13.
- Bounce: ch1 toggles low/high every 3 cycles for 30 cycles, then stays low, delay=10 -> no pulse during bounce; single press_pulse[1] 13 cycles after the final edge.
- Boundary delays:
  - delay=0 -> flip 3 cycles after the edge.
  - Count at 8 when delay is changed from 20 to 5 -> flip on the next cycle.
  - delay=32'hFFFFFFFF -> never flips within the sim window.
- Multi-channel and enable: ch2 and ch3 pressed in the same cycle -> both press pulses in the same cycle. enable=0 during a press -> no change; after enable returns -> press after 1+delay cycles.
- Repeat (macro defined): delay=4, repeat_delay=7, ch0 held 40 cycles -> press_pulse at t+7, then repeat_pulse every 8 cycles; stops on release.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package debounce_pkg;

    localparam int unsigned DEFAULT_CNT_W = 32;
    localparam int unsigned SAT_W         = 64;

    // Raw pin level that means "not pressed".
    function automatic logic inactive_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input int unsigned       width);
        logic [SAT_W-1:0] max_val;
        max_val = {SAT_W{1'b1}} >> (SAT_W - width);
        return (value >= max_val) ? value : value + SAT_W'(1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop synchroniser, stability counter, level and strobes.
// Auto-repeat logic is built only when MULTI_DEBOUNCER_REPEAT_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W      = DEFAULT_CNT_W,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] delay,
    input  logic             raw_in,
`ifdef MULTI_DEBOUNCER_REPEAT_EN
    input  logic [CNT_W-1:0] repeat_delay,
    output logic             repeat_pulse,
`endif
    output logic             pressed,
    output logic             press_pulse,
    output logic             release_pulse
);

    localparam logic INACT = inactive_level(ACTIVE_LOW);

    logic [1:0]       sync_q;
    logic             sample;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             pressed_d;
    logic             press_d;
    logic             release_d;

    assign sample = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

    // Any sample matching the current level, or a frozen filter, restarts the window.
    always_comb begin
        count_d   = '0;
        pressed_d = pressed;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (enable && (sample != pressed)) begin
            if (count_q >= delay) begin
                pressed_d = sample;
                press_d   = sample;
                release_d = ~sample;
            end else begin
                count_d = CNT_W'(sat_inc(SAT_W'(count_q), CNT_W));
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q        <= {2{INACT}};
            count_q       <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], raw_in};
            count_q       <= count_d;
            pressed       <= pressed_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

`ifdef MULTI_DEBOUNCER_REPEAT_EN
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic             repeat_d;

    // Hold counter runs only while the level and the live sample both say pressed.
    always_comb begin
        hold_d   = '0;
        repeat_d = 1'b0;
        if (enable && pressed && sample) begin
            if (hold_q >= repeat_delay) begin
                repeat_d = 1'b1;
            end else begin
                hold_d = CNT_W'(sat_inc(SAT_W'(hold_q), CNT_W));
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q       <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            repeat_pulse <= repeat_d;
        end
    end
`endif

endmodule

// File: rtl/multi_debouncer.sv
// N-channel button/switch debouncer with press/release strobes.
// Define MULTI_DEBOUNCER_REPEAT_EN to add auto-repeat (repeat_delay / repeat_pulse).
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CNT_W      = DEFAULT_CNT_W,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [CNT_W-1:0]    delay,
    input  logic [CHANNELS-1:0] raw_in,
`ifdef MULTI_DEBOUNCER_REPEAT_EN
    input  logic [CNT_W-1:0]    repeat_delay,
    output logic [CHANNELS-1:0] repeat_pulse,
`endif
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .CNT_W      (CNT_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clock         (clock),
            .reset         (reset),
            .enable        (enable),
            .delay         (delay),
            .raw_in        (raw_in[i]),
`ifdef MULTI_DEBOUNCER_REPEAT_EN
            .repeat_delay  (repeat_delay),
            .repeat_pulse  (repeat_pulse[i]),
`endif
            .pressed       (pressed[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule
